checksum_verifier: RTL and testbench
====================================

Name: checksum_verifier

Overview:
- Receive-side counterpart of the ones'-complement checksum generator: checks IPv4/ICMP/UDP-style 16-bit ones'-complement checksums on incoming frames.
- Consumes an 8-bit AXI-Stream frame and sums a configurable byte region, which must include the checksum field.
- Sits on the RX path of the latency measurer. Emits a one-cycle result pulse per frame with pass/fail and the folded sum.

Parameters:
C_OFFSET_WIDTH, 11, width of the region byte offset and the frame byte counter.
C_LENGTH_WIDTH, 11, width of the region byte length.

Ports:
clk  in  1  clock.
rst_n  in  1  reset.
cfg_offset  in  C_OFFSET_WIDTH  byte index of the first summed byte; sampled on the first beat of each frame.
cfg_length  in  C_LENGTH_WIDTH  number of summed bytes; sampled with cfg_offset.
s_axis_tdata  in  8  frame byte.
s_axis_tvalid  in  1  byte valid.
s_axis_tlast  in  1  last byte of the frame.
s_axis_tready  out  1  always 1 after reset; the block never stalls.
result_valid  out  1  one-cycle pulse per frame.
result_ok  out  1  1 = checksum correct; valid with result_valid.
result_short  out  1  1 = frame ended before the region completed.
result_sum  out  16  folded ones'-complement sum of the region.

Behaviour:
- Clocking and reset (already decided): one clock, clk. Reset rst_n is asynchronous and active-low.
- Values while rst_n is low: s_axis_tready=0, result_valid=0, result_ok=0, result_short=0, result_sum=0, state=IDLE.
- Beat definition: a beat is a cycle with s_axis_tvalid=1. Gaps in tvalid are allowed anywhere.
- Byte counting: a byte counter counts beats from 0 within the frame and saturates at its maximum.
- Pairing: bytes are paired big-endian. The even region byte is the high byte and the odd region byte is the low byte.
- Odd-length region: the final byte is padded with 0x00 in the low byte.
- Accumulator: 16 bits. On each completed word, sum <= s[15:0] + s[16], where s = {1'b0,sum} + word. This is an end-around carry.
- FSM states: IDLE, SKIP, SUM, DRAIN, FOLD, REPORT.
  - IDLE: the first beat of a frame latches cfg_offset and cfg_length and clears the sum. That byte is then handled as byte 0 under the SKIP/SUM rules below.
  - SKIP: ignores bytes until the counter equals the offset, then enters SUM.
  - SUM: accumulates bytes. After the byte at index offset+length-1 it goes to FOLD if that beat had tlast, otherwise to DRAIN.
  - DRAIN: discards bytes. On a tlast beat it goes to IDLE; the result has already been reported.
  - FOLD: adds any pending odd byte.
  - REPORT: registers the outputs.
- Latency: result_valid pulses exactly 2 cycles after the beat carrying the final region byte.
- Pass criterion: result_ok = (result_sum == 16'hFFFF).
- cfg_length == 0: no check. result_valid pulses 2 cycles after the frame's tlast beat, with result_ok=1, result_short=0, result_sum=16'hFFFF.
- Short frame: tlast arrives in SKIP, or in SUM before the region's final byte. result_valid pulses 2 cycles after that tlast beat with result_short=1 and result_ok=0. result_sum holds the partial folded sum, or 0 if the frame ended in SKIP.
- Single-byte frame: a beat with tlast in IDLE is handled as above with count 0.
- Back-to-back frames: a first beat may arrive in FOLD or REPORT. It is accepted and starts the next frame immediately. Result registers are not disturbed.
- Result hold: result_sum, result_ok and result_short hold until the next result_valid.
- Offset arithmetic: offset+length is computed at C_OFFSET_WIDTH+1 bits, so there is no wrap. If a region exceeds the counter range, the frame is reported as short.
- Reset mid-frame: all state is cleared asynchronously. No result is produced for the aborted frame.

Optional Feature:
- Macro: CHECKSUM_VERIFIER_ERR_COUNT_EN.
- Defined: adds output err_count (32 bits, reset 0). It increments on every result_valid with result_ok=0 and saturates at 32'hFFFFFFFF.
- Adds input err_count_clr (1 bit). It clears the counter synchronously and has priority over an increment in the same cycle.
- Undefined: neither port exists and no counter logic is generated.

Decomposition:
- Package checksum_pkg holds:
  - the FSM state enum cs_state_t;
  - the constant CS_GOOD = 16'hFFFF;
  - a function cs_add(sum16, word16) returning the end-around-carry sum. It is shared with the generator.
- One sub-module, checksum_accumulator: the 16-bit accumulator with clear, add-word and hold.

Test Plan:
- IPv4 header check: 14 dummy bytes, then 45 00 00 73 00 00 40 00 40 11 B8 61 C0 A8 00 01 C0 A8 00 C7, then 4 bytes and tlast. cfg_offset=14, cfg_length=20. Required: result_valid 2 cycles after the byte C7, result_ok=1, result_sum=FFFF.
- Corrupted checksum: same frame with B8 61 changed to B8 62. Required: result_ok=0, result_sum=0001.
- Odd-length region: bytes 01 02 03 with tlast, offset 0, length 3. Required: result_sum=0402, result_ok=0, result_short=0.
- Short frame: IPv4 frame truncated with tlast on byte index 25 (offset 14, length 20). Required: result_short=1, result_ok=0, pulse 2 cycles after tlast.
- Back-to-back and gaps: two valid frames with zero idle cycles between them and random tvalid gaps. Required: two pulses, both ok=1. The result of frame 1 is unaffected by frame 2's first beat.
- Reset mid-frame: assert rst_n=0 during SUM, then send a valid frame. Required: no pulse for the aborted frame, ok=1 for the new frame. With CHECKSUM_VERIFIER_ERR_COUNT_EN defined, err_count=1 after the corrupted-checksum test.

Source files
------------

// File: rtl/checksum_verifier_pkg.sv
// checksum_verifier_pkg: shared FSM states, good-checksum constant and end-around-carry add
// No ports. Package checksum_pkg is used by the verifier, its accumulator and the generator.
package checksum_pkg;
  typedef enum logic [2:0] {IDLE, SKIP, SUM, DRAIN, FOLD, REPORT} cs_state_t;
  localparam logic [15:0] CS_GOOD = 16'hFFFF;
  function automatic logic [15:0] cs_add(input logic [15:0] sum16, input logic [15:0] word16);
    logic [16:0] s;
    s = {1'b0, sum16} + {1'b0, word16};
    return s[15:0] + {15'd0, s[16]};
  endfunction
endpackage

// File: rtl/checksum_verifier_if.sv
// checksum_verifier_if: byte stream, region config and result bundle of the checksum verifier
// master: drives cfg_* and s_axis_t{data,valid,last}, observes tready and result_*
// slave:  the verifier side
interface checksum_verifier_if #(
  parameter int C_OFFSET_WIDTH = 11,
  parameter int C_LENGTH_WIDTH = 11
);
  logic [C_OFFSET_WIDTH-1:0] cfg_offset;
  logic [C_LENGTH_WIDTH-1:0] cfg_length;
  logic [7:0]                s_axis_tdata;
  logic                      s_axis_tvalid;
  logic                      s_axis_tlast;
  logic                      s_axis_tready;
  logic                      result_valid;
  logic                      result_ok;
  logic                      result_short;
  logic [15:0]               result_sum;
  modport master (
    output cfg_offset, cfg_length, s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready, result_valid, result_ok, result_short, result_sum
  );
  modport slave (
    input  cfg_offset, cfg_length, s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready, result_valid, result_ok, result_short, result_sum
  );
endinterface

// File: rtl/checksum_verifier_accumulator.sv
// checksum_accumulator: 16-bit ones'-complement accumulator with clear, add-word and hold
// Ports: clk, rst_n (async active-low), clr_i (clear, wins over add), add_i, word_i, sum_o.
module checksum_accumulator
  import checksum_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        add_i,
  input  logic [15:0] word_i,
  output logic [15:0] sum_o
);
  logic [15:0] sum_q, sum_d;
  always_comb sum_d = clr_i ? 16'h0000 : add_i ? cs_add(sum_q, word_i) : sum_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sum_q <= '0;
    else sum_q <= sum_d;
  assign sum_o = sum_q;
endmodule

// File: rtl/checksum_verifier.sv
// checksum_verifier: checks the 16-bit ones'-complement checksum over a byte region of each frame
// Ports: clk, rst_n (async active-low), s (checksum_verifier_if.slave: cfg, 8-bit stream, result pulse).
// Optional macro CHECKSUM_VERIFIER_ERR_COUNT_EN adds err_count_clr (in) and err_count (out, 32 bit).
module checksum_verifier
  import checksum_pkg::*;
#(
  parameter int C_OFFSET_WIDTH = 11,
  parameter int C_LENGTH_WIDTH = 11
) (
  input logic clk,
  input logic rst_n,
  checksum_verifier_if.slave s
`ifdef CHECKSUM_VERIFIER_ERR_COUNT_EN
  ,
  input  logic        err_count_clr,
  output logic [31:0] err_count
`endif
);
  localparam int OW = C_OFFSET_WIDTH;
  localparam int LW = C_LENGTH_WIDTH;
  localparam int EW = C_OFFSET_WIDTH + 1;
  cs_state_t   state_q, state_d;
  logic [OW-1:0] off_q, off_d, cnt_q, cnt_d, idx;
  logic [LW-1:0] len_q, len_d;
  logic [EW-1:0] end_w;
  logic [7:0]  pend_q, pend_d;
  logic        pend_v_q, pend_v_d, pv;
  logic        fold_q, fold_d, short_q, short_d, nochk_q, nochk_d;
  logic        beat, first, active, in_reg, last_reg, len_nz;
  logic [15:0] acc_sum, final_sum, sum_q;
  logic        rdy_q, rv_q, ok_q, sh_q;
  // A new frame may start while the previous result is still folding/reporting;
  // the result path reads the pre-edge accumulator, so the restart cannot disturb it.
  always_comb begin
    beat      = s.s_axis_tvalid;
    first     = beat && (state_q == IDLE || state_q == FOLD || state_q == REPORT);
    active    = first || (beat && (state_q == SKIP || state_q == SUM));
    off_d     = first ? s.cfg_offset : off_q;
    len_d     = first ? s.cfg_length : len_q;
    idx       = first ? '0 : cnt_q;
    len_nz    = len_d != '0;
    end_w     = EW'(off_d) + EW'(len_d);
    in_reg    = active && len_nz && idx >= off_d;
    last_reg  = in_reg && (EW'(idx) + EW'(1) == end_w);
    pv        = pend_v_q && !first;
    pend_v_d  = in_reg ? !pv : pv;
    pend_d    = (in_reg && !pv) ? s.s_axis_tdata : pend_q;
    cnt_d     = beat ? (&idx ? idx : idx + OW'(1)) : cnt_q;
    fold_d    = active && (last_reg || s.s_axis_tlast);
    short_d   = len_nz && !last_reg;
    nochk_d   = !len_nz;
    state_d   = active ? (last_reg ? (s.s_axis_tlast ? FOLD : DRAIN) : s.s_axis_tlast ? FOLD : in_reg ? SUM : SKIP)
              : state_q == DRAIN  ? ((beat && s.s_axis_tlast) ? IDLE : DRAIN)
              : state_q == FOLD   ? REPORT
              : state_q == REPORT ? IDLE : state_q;
    // an odd region leaves its last byte pending as the high byte of a zero-padded word
    final_sum = pend_v_q ? cs_add(acc_sum, {pend_q, 8'h00}) : acc_sum;
  end
  checksum_accumulator u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (first),
    .add_i (in_reg && pv),
    .word_i({pend_q, s.s_axis_tdata}),
    .sum_o (acc_sum)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      off_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      fold_q   <= 1'b0;
      short_q  <= 1'b0;
      nochk_q  <= 1'b0;
      rdy_q    <= 1'b0;
      rv_q     <= 1'b0;
      ok_q     <= 1'b0;
      sh_q     <= 1'b0;
      sum_q    <= '0;
    end else begin
      state_q  <= state_d;
      off_q    <= off_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      fold_q   <= fold_d;
      short_q  <= short_d;
      nochk_q  <= nochk_d;
      rdy_q    <= 1'b1;
      rv_q     <= fold_q;
      if (fold_q) begin
        sum_q <= nochk_q ? CS_GOOD : final_sum;
        ok_q  <= nochk_q || (!short_q && final_sum == CS_GOOD);
        sh_q  <= short_q;
      end
    end
  end
  assign s.s_axis_tready = rdy_q;
  assign s.result_valid  = rv_q;
  assign s.result_ok     = ok_q;
  assign s.result_short  = sh_q;
  assign s.result_sum    = sum_q;
`ifdef CHECKSUM_VERIFIER_ERR_COUNT_EN
  logic [31:0] err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= '0;
    else if (err_count_clr) err_q <= '0;
    else if (rv_q && !ok_q && !(&err_q)) err_q <= err_q + 32'd1;
  assign err_count = err_q;
`endif
endmodule

// File: tb/tb_checksum_verifier.sv
// tb_checksum_verifier: directed and randomized frames checked against a frame-level checksum model
module tb_checksum_verifier;
  typedef logic [7:0] q8_t[$];
  typedef struct {int cyc; logic ok; logic sh; logic [15:0] sum;} pulse_t;
  typedef struct {logic ok; logic sh; logic [15:0] sum; int trig;} exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  pulse_t pq[$];
  logic [7:0] hdr [20] = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
                           8'hB8, 8'h61, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  checksum_verifier_if #(.C_OFFSET_WIDTH(11), .C_LENGTH_WIDTH(11)) bus ();
`ifdef CHECKSUM_VERIFIER_ERR_COUNT_EN
  logic        err_count_clr = 1'b0;
  logic [31:0] err_count;
`endif
  checksum_verifier dut (
    .clk  (clk),
    .rst_n(rst_n),
    .s    (bus)
`ifdef CHECKSUM_VERIFIER_ERR_COUNT_EN
    ,
    .err_count_clr(err_count_clr),
    .err_count    (err_count)
`endif
  );

  always @(negedge clk)
    if (rst_n === 1'b1 && bus.result_valid === 1'b1)
      pq.push_back('{cyc, bus.result_ok, bus.result_short, bus.result_sum});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame-level reference: sum the region as big-endian 16-bit words in 32 bits, then fold.
  function automatic exp_t model(input q8_t fr, input int off, input int len);
    exp_t e;
    int n, stop;
    logic [31:0] acc;
    n = fr.size();
    if (len == 0) begin
      e = '{1'b1, 1'b0, 16'hFFFF, n - 1};
      return e;
    end
    stop = (off + len <= n) ? off + len : n;
    acc = 0;
    for (int i = off; i < stop; i += 2)
      acc += {16'h0000, fr[i], ((i + 1 < stop) ? fr[i + 1] : 8'h00)};
    while ((acc >> 16) != 0) acc = (acc & 32'hFFFF) + (acc >> 16);
    e.sum  = acc[15:0];
    e.sh   = off + len > n;
    e.ok   = !e.sh && e.sum == 16'hFFFF;
    e.trig = e.sh ? n - 1 : off + len - 1;
    return e;
  endfunction

  function automatic q8_t mkvalid(input int n, input int off, input int len);
    q8_t f;
    exp_t e;
    logic [15:0] c;
    repeat (n) f.push_back(8'($urandom));
    f[off] = 8'h00;
    f[off + 1] = 8'h00;
    e = model(f, off, len);
    c = ~e.sum;
    f[off] = c[15:8];
    f[off + 1] = c[7:0];
    return f;
  endfunction

  task automatic drive(input q8_t fr, input int off, input int len, input int gap,
                       input int nb, input int trig, output int tc);
    tc = -1;
    for (int i = 0; i < nb; i++) begin
      if (i > 0)
        while ($urandom_range(99) < gap) begin
          @(posedge clk); #1;
          bus.s_axis_tvalid = 1'b0;
        end
      @(posedge clk); #1;
      if (i == 0) begin
        bus.cfg_offset = 11'(off);
        bus.cfg_length = 11'(len);
      end
      if (i == 1) begin
        bus.cfg_offset = 11'($urandom);
        bus.cfg_length = 11'($urandom);
      end
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = fr[i];
      bus.s_axis_tlast  = (i == fr.size() - 1);
      if (i == trig) tc = cyc;
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  task automatic chk_pulse(input string tag, input exp_t e, input int tc);
    pulse_t p;
    int w = 0;
    while (pq.size() == 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_present"}, 32'(pq.size() != 0), 32'd1);
    if (pq.size() == 0) return;
    p = pq.pop_front();
    chk({tag, "_cycle"}, 32'(p.cyc), 32'(tc + 2));
    chk({tag, "_ok"}, 32'(p.ok), 32'(e.ok));
    chk({tag, "_short"}, 32'(p.sh), 32'(e.sh));
    chk({tag, "_sum"}, 32'(p.sum), 32'(e.sum));
  endtask

  task automatic run(input string tag, input q8_t fr, input int off, input int len, input int gap);
    exp_t e;
    int tc;
    e = model(fr, off, len);
    drive(fr, off, len, gap, fr.size(), e.trig, tc);
    idle();
    chk_pulse(tag, e, tc);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    q8_t ip, fr, f1, f2;
    exp_t e1, e2;
    int tc1, tc2, tc;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tdata  = 8'h00;
    bus.cfg_offset    = '0;
    bus.cfg_length    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tready", 32'(bus.s_axis_tready), 32'd0);
    chk("rst_valid", 32'(bus.result_valid), 32'd0);
    chk("rst_ok", 32'(bus.result_ok), 32'd0);
    chk("rst_short", 32'(bus.result_short), 32'd0);
    chk("rst_sum", 32'(bus.result_sum), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("tready_after_rst", 32'(bus.s_axis_tready), 32'd1);

    repeat (14) ip.push_back(8'($urandom));
    foreach (hdr[i]) ip.push_back(hdr[i]);
    repeat (4) ip.push_back(8'($urandom));
    run("ipv4", ip, 14, 20, 20);
    chk("ipv4_sum_const", 32'(bus.result_sum), 32'h0000FFFF);

    fr = ip;
    fr[25] = 8'h62;
    run("corrupt", fr, 14, 20, 0);
    chk("corrupt_sum_const", 32'(bus.result_sum), 32'h00000001);
`ifdef CHECKSUM_VERIFIER_ERR_COUNT_EN
    repeat (2) @(negedge clk);
    chk("err_count", err_count, 32'd1);
    err_count_clr = 1'b1;
    @(negedge clk);
    err_count_clr = 1'b0;
    chk("err_count_clr", err_count, 32'd0);
`endif

    run("odd", '{8'h01, 8'h02, 8'h03}, 0, 3, 0);
    repeat (3) @(negedge clk);
    chk("odd_hold_sum", 32'(bus.result_sum), 32'h00000402);
    chk("odd_hold_short", 32'(bus.result_short), 32'd0);

    fr = {};
    for (int i = 0; i < 26; i++) fr.push_back(ip[i]);
    run("short", fr, 14, 20, 15);
    chk("short_sum_const", 32'(bus.result_sum), 32'h00007DE6);

    run("len0", '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, 2, 0, 0);
    run("single_skip", '{8'hAB}, 3, 4, 0);
    run("single_sum", '{8'hAB}, 0, 2, 0);

    f1 = mkvalid(24, 4, 20);
    f2 = mkvalid(18, 0, 18);
    e1 = model(f1, 4, 20);
    e2 = model(f2, 0, 18);
    drive(f1, 4, 20, 30, f1.size(), e1.trig, tc1);
    drive(f2, 0, 18, 30, f2.size(), e2.trig, tc2);
    idle();
    chk_pulse("b2b_1", e1, tc1);
    chk_pulse("b2b_2", e2, tc2);

    for (int k = 0; k < 12; k++) begin
      int n, off, len;
      n   = $urandom_range(1, 40);
      off = $urandom_range(0, n);
      len = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, n + 3);
      if (off + len <= n && len >= 2 && $urandom_range(0, 1) == 1) fr = mkvalid(n, off, len);
      else begin
        fr = {};
        repeat (n) fr.push_back(8'($urandom));
      end
      run($sformatf("rnd%0d", k), fr, off, len, 25);
    end

    drive(ip, 14, 20, 0, 20, -1, tc);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_tready", 32'(bus.s_axis_tready), 32'd0);
    chk("midrst_sum", 32'(bus.result_sum), 32'd0);
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_no_pulse", 32'(pq.size()), 32'd0);
    run("after_rst", ip, 14, 20, 10);
    chk("after_rst_ok_const", 32'(bus.result_ok), 32'd1);

    repeat (5) @(negedge clk);
    chk("no_extra_pulses", 32'(pq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
